// File: rtl/sd_spi_responder.sv
//-----------------------------------------------------------------------------
// sd_spi_responder
//
// SPI-mode (mode 0) SD-card target used as an on-chip card model. It decodes
// 6-byte command frames, answers with R1, and serves single-block read
// (CMD17) and single-block write (CMD24) transfers from an external
// byte-wide block memory.
//
// Optional build feature:
//   SD_SPI_RESP_CRC_CHECK_EN - when defined, the CRC7 of every command frame
//   is checked and a mismatch is answered with R1 = 0x08 | idle_flag.
//   When undefined, the CRC byte is ignored and no CRC logic exists.
//
// Ports:
//   clk        system clock, at least 8x the sclk frequency
//   rst        asynchronous active-low reset
//   cs         SPI chip select (active low)
//   sclk       SPI clock, mode 0
//   mosi       SPI data from host
//   miso       SPI data to host
//   mem_addr   byte address {block, byte_idx[8:0]}
//   mem_rd_en  read strobe, mem_rdata valid one clk later
//   mem_rdata  read data
//   mem_wr_en  one-clk write strobe
//   mem_wdata  write data
//   idle_flag  card-idle bit, also reported as R1 bit 0
//   debug      {state[3:0], cmd_index[5:0], byte_cnt[9:0], last_r1[7:0], 4'b0}
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module sd_spi_responder #(
    parameter int BLOCK_ADDR_W = 8,
    parameter int NCR_BYTES    = 1,
    parameter int BUSY_BYTES   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    sclk,
    input  logic                    mosi,
    output logic                    miso,
    output logic [BLOCK_ADDR_W+8:0] mem_addr,
    output logic                    mem_rd_en,
    input  logic [7:0]              mem_rdata,
    output logic                    mem_wr_en,
    output logic [7:0]              mem_wdata,
    output logic                    idle_flag,
    output logic [31:0]             debug
);

    typedef enum logic [3:0] {
        CMD_WAIT      = 4'd0,
        CMD_RX        = 4'd1,
        RESP          = 4'd2,
        RD_TOKEN      = 4'd3,
        RD_DATA       = 4'd4,
        RD_CRC        = 4'd5,
        WR_WAIT_TOKEN = 4'd6,
        WR_DATA       = 4'd7,
        WR_CRC        = 4'd8,
        WR_DRESP      = 4'd9,
        WR_BUSY       = 4'd10
    } state_t;

`ifdef SD_SPI_RESP_CRC_CHECK_EN
    // CRC7 (x^7 + x^3 + 1) advanced over one byte, MSB first.
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] crc_v;
        logic       fb_v;
        crc_v = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb_v  = crc_v[6] ^ data[i];
            crc_v = {crc_v[5:0], 1'b0};
            if (fb_v) begin
                crc_v = crc_v ^ 7'h09;
            end else begin
                crc_v = crc_v;
            end
        end
        return crc_v;
    endfunction
`endif

    // Synchroniser and edge-detect state
    logic [1:0] cs_sync_r;
    logic [1:0] sclk_sync_r;
    logic [1:0] mosi_sync_r;
    logic       sclk_prev_r;
    logic       desel_s;
    logic       sclk_rise_s;
    logic       sclk_fall_s;

    // Bit engine
    logic [2:0] bit_cnt_r;
    logic [7:0] rx_shift_r;
    logic [7:0] tx_shift_r;
    logic       load_pending_r;
    logic       byte_done_s;
    logic [7:0] rx_full_s;
    logic [7:0] tx_byte_s;

    // Protocol state
    state_t                  state_r, state_n;
    state_t                  after_resp_r, after_resp_n;
    logic [9:0]              byte_cnt_r, byte_cnt_n;
    logic [5:0]              cmd_index_r, cmd_index_n;
    logic [BLOCK_ADDR_W-1:0] blk_r, blk_n;
    logic [7:0]              r1_r, r1_n;
    logic [7:0]              last_r1_r, last_r1_n;
    logic                    idle_n;
    logic                    crc_ok_s;
`ifdef SD_SPI_RESP_CRC_CHECK_EN
    logic [6:0]              crc_r, crc_n;
`endif

    // Memory request path
    logic                    wr_req_s;
    logic                    rd_req_s;
    logic [BLOCK_ADDR_W+8:0] wr_addr_s;
    logic [BLOCK_ADDR_W+8:0] rd_addr_s;
    logic                    rd_pending_r;
    logic [7:0]              rd_buf_r;

    // Two-flop synchronisers for the SPI pins plus the previous sclk sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync_r   <= 2'b11;
            sclk_sync_r <= 2'b00;
            mosi_sync_r <= 2'b11;
            sclk_prev_r <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[0], cs};
            sclk_sync_r <= {sclk_sync_r[0], sclk};
            mosi_sync_r <= {mosi_sync_r[0], mosi};
            sclk_prev_r <= sclk_sync_r[1];
        end
    end

    assign desel_s     = cs_sync_r[1];
    assign sclk_rise_s = ~desel_s & sclk_sync_r[1] & ~sclk_prev_r;
    assign sclk_fall_s = ~desel_s & ~sclk_sync_r[1] & sclk_prev_r;
    assign byte_done_s = sclk_rise_s & (bit_cnt_r == 3'd7);
    assign rx_full_s   = {rx_shift_r[6:0], mosi_sync_r[1]};
    assign miso        = tx_shift_r[7];

    // Bit engine: sample on rising sclk, shift out on falling sclk, and load the
    // next tx byte one clk after a byte boundary (the FSM has advanced by then).
    // No shift on the falling edge that follows a boundary, so the freshly
    // loaded MSB stays on miso for the first rising edge of the next byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_r      <= 3'd0;
            rx_shift_r     <= 8'h00;
            tx_shift_r     <= 8'hFF;
            load_pending_r <= 1'b0;
        end else if (desel_s) begin
            bit_cnt_r      <= 3'd0;
            tx_shift_r     <= 8'hFF;
            load_pending_r <= 1'b0;
        end else begin
            load_pending_r <= byte_done_s;
            if (sclk_rise_s) begin
                rx_shift_r <= rx_full_s;
                bit_cnt_r  <= bit_cnt_r + 3'd1;
            end
            if (load_pending_r) begin
                tx_shift_r <= tx_byte_s;
            end else if (sclk_fall_s && (bit_cnt_r != 3'd0)) begin
                tx_shift_r <= {tx_shift_r[6:0], 1'b1};
            end
        end
    end

    // Byte to transmit in the slot that starts now, from the advanced state
    always_comb begin
        tx_byte_s = 8'hFF;
        case (state_r)
            RESP:     tx_byte_s = (byte_cnt_r == 10'(NCR_BYTES)) ? r1_r : 8'hFF;
            RD_TOKEN: tx_byte_s = (byte_cnt_r == 10'd1) ? 8'hFE : 8'hFF;
            RD_DATA:  tx_byte_s = rd_buf_r;
            WR_DRESP: tx_byte_s = 8'h05;
            WR_BUSY:  tx_byte_s = (byte_cnt_r == 10'(BUSY_BYTES)) ? 8'hFF : 8'h00;
            default:  tx_byte_s = 8'hFF;
        endcase
    end

`ifdef SD_SPI_RESP_CRC_CHECK_EN
    assign crc_ok_s = (crc_r == rx_full_s[7:1]);
`else
    assign crc_ok_s = 1'b1;
`endif

    // Next-state logic: the FSM advances once per received byte
    always_comb begin
        state_n      = state_r;
        after_resp_n = after_resp_r;
        byte_cnt_n   = byte_cnt_r;
        cmd_index_n  = cmd_index_r;
        blk_n        = blk_r;
        r1_n         = r1_r;
        last_r1_n    = last_r1_r;
        idle_n       = idle_flag;
        wr_req_s     = 1'b0;
        wr_addr_s    = {blk_r, byte_cnt_r[8:0]};
`ifdef SD_SPI_RESP_CRC_CHECK_EN
        crc_n        = crc_r;
`endif
        if (desel_s) begin
            state_n    = CMD_WAIT;
            byte_cnt_n = 10'd0;
        end else if (byte_done_s) begin
            case (state_r)
                CMD_WAIT: begin
                    if (rx_full_s[7:6] == 2'b01) begin
                        state_n     = CMD_RX;
                        cmd_index_n = rx_full_s[5:0];
                        byte_cnt_n  = 10'd1;
                        blk_n       = '0;
`ifdef SD_SPI_RESP_CRC_CHECK_EN
                        crc_n       = crc7_byte(7'd0, rx_full_s);
`endif
                    end else begin
                        state_n = CMD_WAIT;
                    end
                end
                CMD_RX: begin
                    if (byte_cnt_r == 10'd5) begin
                        // CRC byte received: decide R1 from the pre-command idle state
                        state_n    = RESP;
                        byte_cnt_n = 10'd0;
                        if (!crc_ok_s) begin
                            r1_n         = {4'b0000, 1'b1, 2'b00, idle_flag};
                            after_resp_n = CMD_WAIT;
                        end else begin
                            case (cmd_index_r)
                                6'd0: begin
                                    idle_n       = 1'b1;
                                    r1_n         = 8'h01;
                                    after_resp_n = CMD_WAIT;
                                end
                                6'd1, 6'd41: begin
                                    idle_n       = 1'b0;
                                    r1_n         = 8'h00;
                                    after_resp_n = CMD_WAIT;
                                end
                                6'd17: begin
                                    r1_n         = idle_flag ? 8'h05 : 8'h00;
                                    after_resp_n = idle_flag ? CMD_WAIT : RD_TOKEN;
                                end
                                6'd24: begin
                                    r1_n         = idle_flag ? 8'h05 : 8'h00;
                                    after_resp_n = idle_flag ? CMD_WAIT : WR_WAIT_TOKEN;
                                end
                                default: begin
                                    r1_n         = {7'b0000010, idle_flag};
                                    after_resp_n = CMD_WAIT;
                                end
                            endcase
                        end
                        last_r1_n = r1_n;
                    end else begin
                        // Argument bytes arrive MSB first; only the low block bits are kept
                        blk_n      = BLOCK_ADDR_W'({blk_r, rx_full_s});
                        byte_cnt_n = byte_cnt_r + 10'd1;
`ifdef SD_SPI_RESP_CRC_CHECK_EN
                        crc_n      = crc7_byte(crc_r, rx_full_s);
`endif
                    end
                end
                RESP: begin
                    if (byte_cnt_r == 10'(NCR_BYTES)) begin
                        state_n    = after_resp_r;
                        byte_cnt_n = 10'd0;
                    end else begin
                        byte_cnt_n = byte_cnt_r + 10'd1;
                    end
                end
                RD_TOKEN, RD_CRC, WR_CRC: begin
                    if (byte_cnt_r == 10'd1) begin
                        byte_cnt_n = 10'd0;
                        state_n    = (state_r == RD_TOKEN) ? RD_DATA :
                                     (state_r == RD_CRC)   ? CMD_WAIT : WR_DRESP;
                    end else begin
                        byte_cnt_n = byte_cnt_r + 10'd1;
                    end
                end
                RD_DATA: begin
                    if (byte_cnt_r == 10'd511) begin
                        state_n    = RD_CRC;
                        byte_cnt_n = 10'd0;
                    end else begin
                        byte_cnt_n = byte_cnt_r + 10'd1;
                    end
                end
                WR_WAIT_TOKEN: begin
                    if (rx_full_s == 8'hFE) begin
                        state_n    = WR_DATA;
                        byte_cnt_n = 10'd0;
                    end else begin
                        state_n = WR_WAIT_TOKEN;
                    end
                end
                WR_DATA: begin
                    wr_req_s = 1'b1;
                    if (byte_cnt_r == 10'd511) begin
                        state_n    = WR_CRC;
                        byte_cnt_n = 10'd0;
                    end else begin
                        byte_cnt_n = byte_cnt_r + 10'd1;
                    end
                end
                WR_DRESP: begin
                    state_n    = WR_BUSY;
                    byte_cnt_n = 10'd0;
                end
                WR_BUSY: begin
                    if (byte_cnt_r == 10'(BUSY_BYTES)) begin
                        state_n    = CMD_WAIT;
                        byte_cnt_n = 10'd0;
                    end else begin
                        byte_cnt_n = byte_cnt_r + 10'd1;
                    end
                end
                default: begin
                    state_n    = CMD_WAIT;
                    byte_cnt_n = 10'd0;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Read requests are raised when a tx slot is loaded: byte 0 during the
    // token slot, then byte n+1 while byte n is shifting out.
    always_comb begin
        rd_req_s  = 1'b0;
        rd_addr_s = {blk_r, 9'd0};
        if (load_pending_r && !desel_s) begin
            case (state_r)
                RD_TOKEN: begin
                    rd_req_s  = (byte_cnt_r == 10'd1);
                    rd_addr_s = {blk_r, 9'd0};
                end
                RD_DATA: begin
                    rd_req_s  = (byte_cnt_r != 10'd511);
                    rd_addr_s = {blk_r, byte_cnt_r[8:0] + 9'd1};
                end
                default: begin
                    rd_req_s  = 1'b0;
                    rd_addr_s = {blk_r, 9'd0};
                end
            endcase
        end else begin
            rd_req_s = 1'b0;
        end
    end

    // FSM state register and card status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= CMD_WAIT;
            after_resp_r <= CMD_WAIT;
            byte_cnt_r   <= 10'd0;
            cmd_index_r  <= 6'd0;
            blk_r        <= '0;
            r1_r         <= 8'h00;
            last_r1_r    <= 8'h00;
            idle_flag    <= 1'b1;
            debug        <= 32'h0000_0000;
`ifdef SD_SPI_RESP_CRC_CHECK_EN
            crc_r        <= 7'd0;
`endif
        end else begin
            state_r      <= state_n;
            after_resp_r <= after_resp_n;
            byte_cnt_r   <= byte_cnt_n;
            cmd_index_r  <= cmd_index_n;
            blk_r        <= blk_n;
            r1_r         <= r1_n;
            last_r1_r    <= last_r1_n;
            idle_flag    <= idle_n;
            debug        <= {state_n, cmd_index_n, byte_cnt_n, last_r1_n, 4'b0000};
`ifdef SD_SPI_RESP_CRC_CHECK_EN
            crc_r        <= crc_n;
`endif
        end
    end

    // Memory port: registered strobes, write wins over read, read data captured one clk after the strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wr_en    <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 8'h00;
            rd_pending_r <= 1'b0;
            rd_buf_r     <= 8'hFF;
        end else begin
            mem_wr_en    <= wr_req_s;
            mem_rd_en    <= rd_req_s & ~wr_req_s;
            rd_pending_r <= mem_rd_en;
            if (wr_req_s) begin
                mem_addr  <= wr_addr_s;
                mem_wdata <= rx_full_s;
            end else if (rd_req_s) begin
                mem_addr  <= rd_addr_s;
            end
            if (rd_pending_r) begin
                rd_buf_r <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
`timescale 1ns/1ps

module tb_sd_spi_responder;

    localparam int AW   = 17;
    localparam int HALF = 40;      // sclk half period = 4 clk (clk = 8x sclk)

    logic          clk;
    logic          rst;
    logic          cs;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_rdata;
    logic          mem_wr_en;
    logic [7:0]    mem_wdata;
    logic          idle_flag;
    logic [31:0]   debug;

    sd_spi_responder #(
        .BLOCK_ADDR_W(8),
        .NCR_BYTES(1),
        .BUSY_BYTES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cs(cs),
        .sclk(sclk),
        .mosi(mosi),
        .miso(miso),
        .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata),
        .idle_flag(idle_flag),
        .debug(debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block memory model plus access logs
    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] rd_log [0:2047];
    logic [AW-1:0] wr_log [0:2047];
    int            rd_count = 0;
    int            wr_count = 0;
    int            both_count = 0;

    always @(posedge clk) begin
        if (mem_rd_en && mem_wr_en) both_count++;
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr];
            if (rd_count < 2048) rd_log[rd_count] = mem_addr;
            rd_count++;
        end
        if (mem_wr_en) begin
            mem[mem_addr] = mem_wdata;
            if (wr_count < 2048) wr_log[wr_count] = mem_addr;
            wr_count++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full-duplex SPI byte, mode 0, host samples miso on the rising edge
    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #(HALF);
            sclk = 1'b1;
            rx[i] = miso;
            #(HALF);
            sclk = 1'b0;
        end
    endtask

    // Reference CRC7 over the 40 command bits
    function automatic logic [6:0] tb_crc7(input logic [39:0] msg);
        logic [6:0] r;
        r = 7'd0;
        for (int k = 39; k >= 0; k--) begin
            if (r[6] ^ msg[k]) r = {r[5:0], 1'b0} ^ 7'h09;
            else               r = {r[5:0], 1'b0};
        end
        return r;
    endfunction

    // Send a command frame, then clock out the Ncr filler byte and R1
    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic bad_crc,
                            output logic [7:0] ncr_b, output logic [7:0] r1_b);
        logic [47:0] frame;
        logic [7:0]  dummy;
        frame[47:8] = {2'b01, idx, arg};
        frame[7:0]  = bad_crc ? 8'h00 : {tb_crc7(frame[47:8]), 1'b1};
        for (int b = 5; b >= 0; b--) spi_xfer(frame[b*8 +: 8], dummy);
        spi_xfer(8'hFF, ncr_b);
        spi_xfer(8'hFF, r1_b);
    endtask

    logic [7:0] ncr, r1, b;
    int         base, errs;

    initial begin
        rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b1;
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'h00;
        for (int a = 0; a < 512; a++) mem[17'h600 + a] = a[7:0];
        #22;
        chk("rst_miso", {31'd0, miso}, 32'd1);
        chk("rst_idle", {31'd0, idle_flag}, 32'd1);
        chk("rst_debug", debug, 32'd0);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_addr", {15'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        #10 rst = 1'b1;
        #40;
        cs = 1'b0;
        #80;

        // CMD0 -> one FF then R1 = 0x01
        send_cmd(6'd0, 32'h0, 1'b0, ncr, r1);
        chk("cmd0_ncr", {24'd0, ncr}, 32'hFF);
        chk("cmd0_r1", {24'd0, r1}, 32'h01);
        chk("cmd0_idle", {31'd0, idle_flag}, 32'd1);

        // CMD17 while idle -> illegal, no memory access
        base = rd_count;
        send_cmd(6'd17, 32'h3, 1'b0, ncr, r1);
        spi_xfer(8'hFF, b);
        spi_xfer(8'hFF, b);
        chk("cmd17_idle_r1", {24'd0, r1}, 32'h05);
        chk("cmd17_idle_reads", rd_count - base, 32'd0);

        // CMD1 -> leaves idle
        send_cmd(6'd1, 32'h0, 1'b0, ncr, r1);
        chk("cmd1_r1", {24'd0, r1}, 32'h00);
        chk("cmd1_idle", {31'd0, idle_flag}, 32'd0);

        // Unsupported CMD9 after init -> illegal command
        send_cmd(6'd9, 32'h0, 1'b0, ncr, r1);
        chk("cmd9_r1", {24'd0, r1}, 32'h04);

        // CMD17 block 3
        base = rd_count;
        send_cmd(6'd17, 32'h3, 1'b0, ncr, r1);
        chk("cmd17_ncr", {24'd0, ncr}, 32'hFF);
        chk("cmd17_r1", {24'd0, r1}, 32'h00);
        spi_xfer(8'hFF, b);
        chk("cmd17_gap", {24'd0, b}, 32'hFF);
        spi_xfer(8'hFF, b);
        chk("cmd17_token", {24'd0, b}, 32'hFE);
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            spi_xfer(8'hFF, b);
            if (b !== i[7:0]) errs++;
        end
        chk("cmd17_data_errs", errs, 32'd0);
        spi_xfer(8'hFF, b);
        chk("cmd17_crc0", {24'd0, b}, 32'hFF);
        spi_xfer(8'hFF, b);
        chk("cmd17_crc1", {24'd0, b}, 32'hFF);
        chk("cmd17_reads", rd_count - base, 32'd512);
        errs = 0;
        for (int i = 0; i < 512; i++) if (rd_log[base + i] !== AW'(17'h600 + i)) errs++;
        chk("cmd17_addr_errs", errs, 32'd0);
        #50;
        chk("cmd17_end_state", {28'd0, debug[31:28]}, 32'd0);

        // CMD24 arg 0x105 -> block 5
        base = wr_count;
        send_cmd(6'd24, 32'h105, 1'b0, ncr, r1);
        chk("cmd24_r1", {24'd0, r1}, 32'h00);
        spi_xfer(8'hFE, b);
        for (int i = 0; i < 512; i++) spi_xfer(8'hA5, b);
        spi_xfer(8'hFF, b);
        spi_xfer(8'hFF, b);
        spi_xfer(8'hFF, b);
        chk("cmd24_dresp", {24'd0, b}, 32'h05);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            spi_xfer(8'hFF, b);
            if (b !== 8'h00) errs++;
        end
        chk("cmd24_busy_errs", errs, 32'd0);
        spi_xfer(8'hFF, b);
        chk("cmd24_ready", {24'd0, b}, 32'hFF);
        chk("cmd24_writes", wr_count - base, 32'd512);
        errs = 0;
        for (int i = 0; i < 512; i++) if (wr_log[base + i] !== AW'(17'hA00 + i)) errs++;
        chk("cmd24_addr_errs", errs, 32'd0);
        chk("cmd24_mem_first", {24'd0, mem[17'hA00]}, 32'hA5);
        chk("cmd24_mem_last", {24'd0, mem[17'hBFF]}, 32'hA5);
        chk("cmd24_no_overrun", {24'd0, mem[17'hC00]}, 32'h00);
        chk("rd_wr_overlap", both_count, 32'd0);

        // CMD24 to block 7 aborted by cs after 100 data bytes
        base = wr_count;
        send_cmd(6'd24, 32'h7, 1'b0, ncr, r1);
        chk("abort_r1", {24'd0, r1}, 32'h00);
        spi_xfer(8'hFE, b);
        for (int i = 0; i < 100; i++) spi_xfer(8'h3C, b);
        #20 cs = 1'b1;
        #100;
        chk("abort_writes", wr_count - base, 32'd100);
        chk("abort_state", {28'd0, debug[31:28]}, 32'd0);
        chk("abort_miso", {31'd0, miso}, 32'd1);
        chk("abort_mem_99", {24'd0, mem[17'hE63]}, 32'h3C);
        chk("abort_mem_100", {24'd0, mem[17'hE64]}, 32'h00);
        cs = 1'b0;
        #80;
        send_cmd(6'd0, 32'h0, 1'b0, ncr, r1);
        chk("abort_cmd0_r1", {24'd0, r1}, 32'h01);

        // CMD0 with a wrong CRC byte (40 00 00 00 00 00)
        send_cmd(6'd0, 32'h0, 1'b1, ncr, r1);
`ifdef SD_SPI_RESP_CRC_CHECK_EN
        chk("crc_bad_r1", {24'd0, r1}, 32'h09);
`else
        chk("crc_ignored_r1", {24'd0, r1}, 32'h01);
`endif

        cs = 1'b1;
        #100;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- SPI-mode SD-card target. It answers the sdspihost initiator: decodes 6-byte SD command frames, returns R1 responses, and serves single-block read (CMD17) and write (CMD24) transfers from an external byte-wide block memory.
- Used as an on-chip card model for autotest loopback and for host-side verification without a physical card.

Parameters:
- BLOCK_ADDR_W, 8, number of block-address bits taken from the command argument (2^BLOCK_ADDR_W blocks of 512 bytes).
- NCR_BYTES, 1, number of 0xFF filler bytes between the command CRC byte and the R1 byte (range 1..8).
- BUSY_BYTES, 4, number of 0x00 busy bytes after the write data-response byte.

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- rst  in  1  asynchronous, active-low reset.
- cs  in  1  SPI chip select, active low.
- sclk  in  1  SPI clock, mode 0.
- mosi  in  1  SPI data from host.
- miso  out  1  SPI data to host.
- mem_addr  out  BLOCK_ADDR_W+9  byte address {block, byte_idx[8:0]}.
- mem_rd_en  out  1  read strobe; mem_rdata is valid one clk later.
- mem_rdata  in  8  read data.
- mem_wr_en  out  1  one-clk write strobe.
- mem_wdata  out  8  write data.
- idle_flag  out  1  card-idle bit, also reported as R1 bit 0.
- debug  out  32  {state[3:0], cmd_index[5:0], byte_cnt[9:0], last_r1[7:0], 4'b0}.

Behaviour:
- Reset values: miso=1, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, idle_flag=1, debug=0, state=CMD_WAIT.
- Input synchronisation: cs, sclk and mosi pass through 2-flop synchronisers. sclk edges are detected from the synchronised signal.
- Bit timing (mode 0):
  - mosi is sampled on each sclk rising edge.
  - miso shifts on each sclk falling edge.
  - At every byte boundary the next tx byte is loaded and its MSB is driven within 2 clk, before the next rising edge.
- cs high:
  - bit counter is cleared; miso=1; state returns to CMD_WAIT.
  - Any in-flight transfer is aborted. Bytes already written stay written, and no response is generated.
- Default tx byte is 0xFF in every state not listed below.
- CMD_WAIT: a received byte with bits[7:6]=01 starts a frame. Go to CMD_RX, capture the index, byte_cnt=1.
- CMD_RX: collect the 4 argument bytes and the CRC byte. Then go to RESP.
- RESP: send NCR_BYTES x 0xFF, then R1. R1 is decided as follows:
  - CMD0: idle_flag<=1; R1=0x01.
  - CMD1 or CMD41: idle_flag<=0; R1=0x00.
  - CMD17/CMD24 with idle_flag=1: R1=0x05 (illegal), then back to CMD_WAIT.
  - CMD17/CMD24 with idle_flag=0: R1=0x00, then RD_TOKEN or WR_WAIT_TOKEN respectively.
  - Any other index: R1=0x04|idle_flag, then CMD_WAIT.
  - Block number = argument[BLOCK_ADDR_W-1:0]. Upper argument bits are ignored, so addressing wraps modulo 2^BLOCK_ADDR_W.
- RD_TOKEN: send one 0xFF, then 0xFE. Issue mem_rd_en for byte 0 during the token byte.
- RD_DATA: send 512 bytes, byte_idx 0..511.
  - Byte n+1 is prefetched during byte n; each mem_rd_en is a 1-clk pulse.
  - byte_idx wraps at 511 into RD_CRC; no read is issued past 511.
- RD_CRC: send 0xFF, 0xFF, then CMD_WAIT.
- WR_WAIT_TOKEN: ignore received bytes until 0xFE. A frame start byte (01xxxxxx) is not honoured here.
- WR_DATA: receive 512 bytes. Pulse mem_wr_en for 1 clk after each full byte, with mem_addr={block,byte_idx}.
- WR_CRC: discard 2 bytes.
- WR_DRESP: send 0x05.
- WR_BUSY: send BUSY_BYTES x 0x00, then 0xFF, then CMD_WAIT.
- Write port wins: mem_rd_en and mem_wr_en are never asserted in the same clk.
- A frame-start byte arriving while a response is in progress is ignored; full-duplex commands are not supported.

Optional Feature:
- Macro SD_SPI_RESP_CRC_CHECK_EN.
- Defined: CRC7 (poly 0x09) is computed over command bytes 0..4 and compared with CRC byte bits[7:1]. On mismatch, R1=0x08|idle_flag, no state effect, return to CMD_WAIT.
- Not defined: the CRC byte is ignored and no CRC logic is synthesised.

Test Plan:
- Reset → miso=1, idle_flag=1. Send 40 00 00 00 00 95 → after 1 FF the host reads R1=0x01.
- CMD0, then 41 00 00 00 00 FF → R1=0x00, idle_flag=0.
- Memory preloaded with byte = addr[7:0] for block 3. CMD17 arg 0x00000003 → R1 00, FF, FE, bytes 00..FF,00..FF (512 total), FF FF. 512 mem_rd_en pulses, addresses 0x600..0x7FF.
- CMD24 arg 0x105 (BLOCK_ADDR_W=8 → block 5), token FE, 512 bytes of 0xA5, 2 CRC bytes → response 05, 4x 00, then FF. 512 writes to 0xA00..0xBFF.
- CMD17 while idle → R1=0x05 and no memory access. Command index 9 after init → R1=0x04.
- cs deasserted after 100 data bytes of a CMD24 → exactly 100 writes, state CMD_WAIT. A following CMD0 answers 0x01.
- (SD_SPI_RESP_CRC_CHECK_EN defined) 40 00 00 00 00 00 → R1=0x09.
